// File: rtl/conv_stream_rx.sv
// Receiver/checker for the conv core output frame stream: framing FSM, geometry checks, sticky errors, per-frame stats.
// Optional per-frame pixel checksum output enabled by defining CONV_RX_CHECKSUM_EN.
module conv_stream_rx #(
  parameter int DW    = 16,
  parameter int EXP_W = 30,
  parameter int EXP_H = 33,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pix_in,
  input  logic          valid_in,
  input  logic          frame_start_in,
  input  logic          line_start_in,
  input  logic          frame_end_in,
  input  logic          err_clr,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic [CW-1:0] lines_rcvd,
  output logic [CW-1:0] last_width,
  output logic [3:0]    err_flags,
  output logic          busy,
`ifdef CONV_RX_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic [1:0]    state_dbg
);

  // Stream contract: no backpressure. A beat is transferred on every rising
  // edge where valid_in=1; line_start_in/frame_end_in qualify that beat only.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_IN_FRAME = 2'd2} state_t;

  localparam logic [CW-1:0] EXP_W_C = CW'(EXP_W);
  localparam logic [CW-1:0] EXP_H_C = CW'(EXP_H);

  state_t        state_q, state_d;
  logic [CW-1:0] pix_q, pix_d, line_q, line_d;
  logic [CW-1:0] lines_q, lines_d, lastw_q, lastw_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [3:0]    err_q, err_d, new_err;
  logic          done_q, done_d;
  logic          in_frame, closing, beat_ok;
  logic [CW-1:0] beat_pix, beat_line;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    lines_d     = lines_q;
    lastw_d     = lastw_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    new_err     = '0;
    beat_ok     = 1'b0;
    beat_pix    = pix_q;
    beat_line   = line_q;
    in_frame    = (state_q != S_IDLE);
    closing     = valid_in && frame_end_in && in_frame;

    if (frame_start_in && in_frame && !closing) begin
      // Restart abandons the open frame; any beat in this cycle belongs to nothing.
      new_err[3] = 1'b1;
      state_d    = S_ARMED;
      pix_d      = '0;
      line_d     = '0;
    end else begin
      if (valid_in && !in_frame) begin
        new_err[2] = 1'b1;
      end else if (valid_in) begin
        beat_ok = 1'b1;
        if (state_q == S_ARMED) begin
          if (!line_start_in) new_err[0] = 1'b1;
          beat_line = {{(CW-1){1'b0}}, 1'b1};
          beat_pix  = {{(CW-1){1'b0}}, 1'b1};
        end else if (line_start_in) begin
          if (pix_q != EXP_W_C) new_err[0] = 1'b1;
          beat_line = sat_inc(line_q);
          beat_pix  = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          beat_pix  = sat_inc(pix_q);
        end
        pix_d   = beat_pix;
        line_d  = beat_line;
        state_d = S_IN_FRAME;
        if (frame_end_in) begin
          if (beat_pix != EXP_W_C)  new_err[0] = 1'b1;
          if (beat_line != EXP_H_C) new_err[1] = 1'b1;
          lines_d     = beat_line;
          lastw_d     = beat_pix;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      // A start coinciding with a closing beat simply re-arms after the close.
      if (frame_start_in) begin
        state_d = S_ARMED;
        pix_d   = '0;
        line_d  = '0;
      end
    end

    err_d = (err_clr ? 4'b0000 : err_q) | new_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      line_q      <= '0;
      lines_q     <= '0;
      lastw_q     <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      lines_q     <= lines_d;
      lastw_q     <= lastw_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

`ifdef CONV_RX_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, chk_q, chk_d;

  always_comb begin
    acc_d = acc_q;
    chk_d = chk_q;
    if (beat_ok) acc_d = acc_q + 32'(pix_in);
    if (closing) chk_d = acc_d;
    if (frame_start_in) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      chk_q <= '0;
    end else begin
      acc_q <= acc_d;
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`else
  logic unused_pix;
  assign unused_pix = ^{pix_in, beat_ok};
`endif

  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign lines_rcvd = lines_q;
  assign last_width = lastw_q;
  assign err_flags  = err_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_stream_rx.sv
// Bench for conv_stream_rx: frame-level reference model with a per-cycle compare, plus directed frame scenarios.
// Checksum output is checked when CONV_RX_CHECKSUM_EN is defined.
module tb_conv_stream_rx;
  localparam int DW    = 16;
  localparam int EXP_W = 30;
  localparam int EXP_H = 33;
  localparam int CW    = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          valid_in = 1'b0, frame_start_in = 1'b0, line_start_in = 1'b0;
  logic          frame_end_in = 1'b0, err_clr = 1'b0;
  logic          frame_done, busy;
  logic [15:0]   frame_cnt;
  logic [CW-1:0] lines_rcvd, last_width;
  logic [3:0]    err_flags;
  logic [1:0]    state_dbg;
`ifdef CONV_RX_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  conv_stream_rx #(.DW(DW), .EXP_W(EXP_W), .EXP_H(EXP_H), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .valid_in(valid_in),
    .frame_start_in(frame_start_in), .line_start_in(line_start_in),
    .frame_end_in(frame_end_in), .err_clr(err_clr),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .lines_rcvd(lines_rcvd),
    .last_width(last_width), .err_flags(err_flags), .busy(busy),
`ifdef CONV_RX_CHECKSUM_EN
    .checksum(checksum),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame as a list of line widths ----------------
  bit          m_open;
  int          widths[$];
  logic [3:0]  m_err;
  logic        m_done;
  logic [15:0] m_cnt;
  int          m_lines, m_lastw;
  logic [31:0] m_sum, m_chk;

  task automatic model_reset();
    m_open = 0; widths.delete(); m_err = '0; m_done = 0; m_cnt = '0;
    m_lines = 0; m_lastw = 0; m_sum = '0; m_chk = '0;
  endtask

  task automatic model_step();
    logic [3:0] ne;
    bit closing;
    ne = '0;
    m_done = 0;
    closing = valid_in && frame_end_in && m_open;
    if (frame_start_in && m_open && !closing) begin
      ne[3] = 1; widths.delete(); m_sum = '0;
    end else begin
      if (valid_in && !m_open) ne[2] = 1;
      else if (valid_in) begin
        m_sum = m_sum + 32'(pix_in);
        if (widths.size() == 0) begin
          if (!line_start_in) ne[0] = 1;
          widths.push_back(1);
        end else if (line_start_in) begin
          if (widths[$] != EXP_W) ne[0] = 1;
          widths.push_back(1);
        end else widths[$] = widths[$] + 1;
        if (frame_end_in) begin
          if (widths[$] != EXP_W) ne[0] = 1;
          if (widths.size() != EXP_H) ne[1] = 1;
          m_lines = widths.size(); m_lastw = widths[$];
          m_done = 1; m_cnt = m_cnt + 16'd1; m_chk = m_sum; m_open = 0;
        end
      end
      if (frame_start_in) begin
        m_open = 1; widths.delete(); m_sum = '0;
      end
    end
    m_err = (err_clr ? 4'b0000 : m_err) | ne;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cmp_frame_done", 32'(frame_done), 32'(m_done));
    chk("cmp_frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("cmp_lines_rcvd", 32'(lines_rcvd), 32'(m_lines));
    chk("cmp_last_width", 32'(last_width), 32'(m_lastw));
    chk("cmp_err_flags", 32'(err_flags), 32'(m_err));
    chk("cmp_busy", 32'(busy), 32'(m_open));
`ifdef CONV_RX_CHECKSUM_EN
    chk("cmp_checksum", checksum, m_chk);
`endif
    if (frame_done === 1'b1) done_seen++;
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int pix, input bit ls, input bit fe);
    valid_in = 1; pix_in = DW'(pix); line_start_in = ls; frame_end_in = fe;
    tick();
    valid_in = 0; pix_in = '0; line_start_in = 0; frame_end_in = 0;
  endtask

  // Lines numbered from 0, columns from 1: pixel = line*EXP_W + col.
  task automatic send_lines(input int nl, input int sl, input int sw, input int tail, input bit close);
    for (int l = 0; l < nl; l++) begin
      int w;
      w = (l == sl) ? sw : EXP_W;
      for (int c = 1; c <= w; c++) beat(l * EXP_W + c, c == 1, close && (l == nl - 1) && (c == w));
    end
    for (int c = 1; c <= tail; c++) beat(nl * EXP_W + c, c == 1, 1'b0);
  endtask

  task automatic start_pulse();
    frame_start_in = 1; tick(); frame_start_in = 0; tick();
  endtask

  task automatic frame(input int nl, input int sl, input int sw);
    start_pulse();
    send_lines(nl, sl, sw, 0, 1'b1);
  endtask

  task automatic clear_err();
    err_clr = 1; tick(); err_clr = 0; tick();
  endtask

  initial begin
    int base;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset_err", 32'(err_flags), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_lines", 32'(lines_rcvd), 32'd0);

    // 1: nominal frame
    frame(EXP_H, -1, 0);
    chk("t1_done_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("t1_done_gone", 32'(frame_done), 32'd0);
    chk("t1_lines", 32'(lines_rcvd), 32'd33);
    chk("t1_width", 32'(last_width), 32'd30);
    chk("t1_err", 32'(err_flags), 32'd0);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
`ifdef CONV_RX_CHECKSUM_EN
    chk("t1_checksum", checksum, 32'd490545);
`endif
    repeat (2) tick();

    // 2: line 5 short by one pixel
    frame(EXP_H, 5, 29);
    tick();
    chk("t2_err", 32'(err_flags), 32'b0001);
    chk("t2_lines", 32'(lines_rcvd), 32'd33);
    chk("t2_cnt", 32'(frame_cnt), 32'd2);
    clear_err();

    // 3: frame ends one line early, then error clear
    frame(32, -1, 0);
    tick();
    chk("t3_err", 32'(err_flags), 32'b0010);
    chk("t3_lines", 32'(lines_rcvd), 32'd32);
    chk("t3_width", 32'(last_width), 32'd30);
    err_clr = 1; tick(); err_clr = 0;
    chk("t3_err_cleared", 32'(err_flags), 32'd0);
    tick();

    // 4: stray beat while idle, then nominal frame
    beat(16'h55, 1'b0, 1'b0);
    chk("t4_stray_err", 32'(err_flags), 32'b0100);
    chk("t4_stray_idle", 32'(busy), 32'd0);
    frame(EXP_H, -1, 0);
    tick();
    chk("t4_err", 32'(err_flags), 32'b0100);
    chk("t4_lines", 32'(lines_rcvd), 32'd33);
    chk("t4_width", 32'(last_width), 32'd30);
    chk("t4_cnt", 32'(frame_cnt), 32'd4);
    clear_err();

    // 5: restart in the middle of line 10
    base = done_seen;
    start_pulse();
    send_lines(9, -1, 0, 15, 1'b0);
    frame(EXP_H, -1, 0);
    repeat (2) tick();
    chk("t5_err", 32'(err_flags), 32'b1000);
    chk("t5_cnt", 32'(frame_cnt), 32'd5);
    chk("t5_done_pulses", 32'(done_seen - base), 32'd1);
    chk("t5_lines", 32'(lines_rcvd), 32'd33);
    clear_err();

    // 6: reset during line 20
    start_pulse();
    send_lines(19, -1, 0, 10, 1'b0);
    rst_n = 0;
    #1;
    chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_lines", 32'(lines_rcvd), 32'd0);
    chk("t6_rst_width", 32'(last_width), 32'd0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    frame(EXP_H, -1, 0);
    tick();
    chk("t6_cnt", 32'(frame_cnt), 32'd1);
    chk("t6_err", 32'(err_flags), 32'd0);
    chk("t6_lines", 32'(lines_rcvd), 32'd33);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_stream_rx.md
Name: conv_stream_rx

Overview:
Synthesizable receiver for the convolution output frame stream (pixel data, out_valid, frame_start_out, line_start_out, frame_end_out). It tracks frame/line framing, counts pixels per line and lines per frame against expected geometry, and raises sticky protocol errors. It also reports per-frame statistics. It sits at the conv core output, ahead of the result writer, and doubles as an on-chip stream checker in system sims.

Parameters:
DW, 16, pixel data width
EXP_W, 30, expected valid pixels per line (32-wide input, 3x3 valid window)
EXP_H, 33, expected lines per frame (35-line input)
CW, 12, width of pixel/line counters (must hold max(EXP_W, EXP_H)+1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
pix_in  in  DW  output pixel from conv core, qualified by valid_in
valid_in  in  1  pixel beat valid (conv out_valid)
frame_start_in  in  1  1-cycle pulse, at least 1 cycle before first valid beat of a frame
line_start_in  in  1  coincides with first valid beat of each line
frame_end_in  in  1  coincides with last valid beat of frame
err_clr  in  1  synchronous clear of sticky error flags
frame_done  out  1  1-cycle pulse, cycle after frame_end beat accepted
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
lines_rcvd  out  CW  line count of last completed frame
last_width  out  CW  pixel count of final line of last completed frame
err_flags  out  4  sticky: [0] width mismatch, [1] height mismatch, [2] beat outside frame, [3] frame_start while in frame
busy  out  1  high in ARMED or IN_FRAME

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal pix/line counters 0.
- FSM states: IDLE, ARMED, IN_FRAME.
- IDLE: frame_start_in -> ARMED, counters cleared. valid_in in IDLE -> err_flags[2] set, beat dropped.
- ARMED: waits for first valid_in. First beat must carry line_start_in; if not, set err_flags[0] and still treat it as line start. -> IN_FRAME, line_cnt=1, pix_cnt=1.
- IN_FRAME, valid beat with line_start_in: if pix_cnt != EXP_W, set err_flags[0]. Then line_cnt+=1, pix_cnt=1.
- IN_FRAME, valid beat without line_start_in: pix_cnt+=1, saturating at 2^CW-1.
- Beats without valid_in are ignored. line_start_in/frame_end_in without valid_in are ignored.
- frame_end_in with valid_in in IN_FRAME:
  - The beat is counted first.
  - final pix_cnt != EXP_W sets err_flags[0]; line_cnt != EXP_H sets err_flags[1].
  - Next cycle: lines_rcvd/last_width update, frame_done=1 for exactly 1 cycle, frame_cnt+=1, state IDLE.
- Same beat carrying line_start_in and frame_end_in: one-pixel line. Line check on the previous line, then final-line check against 1.
- frame_start_in in ARMED or IN_FRAME: set err_flags[3], abandon current frame (no frame_done, no frame_cnt change), restart in ARMED.
- frame_start_in in the same cycle as a frame_end beat: frame closes normally (frame_done next cycle), then ARMED. No err_flags[3].
- Error flags:
  - err_flags are sticky OR-accumulate.
  - err_clr clears them the next edge.
  - A new error in the same cycle as err_clr wins (flag stays/gets set).
- Latency: statistics and frame_done 1 cycle after the frame_end beat. No backpressure; accepts one beat per cycle.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is lost, and the first frame after release starts from IDLE.

Optional Feature:
Macro CONV_RX_CHECKSUM_EN.
- Defined: adds output checksum [31:0].
  - Running sum mod 2^32 of zero-extended pix_in over all valid beats of a frame.
  - Registered alongside lines_rcvd, so it updates with frame_done.
  - Internal accumulator cleared on frame_start_in.
  - checksum resets to 0.
- Undefined: port and accumulator absent; all other behaviour identical.

Test Plan:
1. Nominal frame: frame_start, 33 lines x 30 beats, pix = line*30+col -> frame_done pulse 1 cycle after last beat; lines_rcvd=33, last_width=30, err_flags=0, frame_cnt=1. With CONV_RX_CHECKSUM_EN: checksum=490545.
2. Short line: line 5 has 29 beats, rest nominal -> err_flags=4'b0001, frame_done still pulses, lines_rcvd=33.
3. Short frame: frame_end on 32nd line, 30th beat -> err_flags=4'b0010, lines_rcvd=32, last_width=30; then err_clr -> err_flags=0 next cycle.
4. Stray beat: valid_in=1 while IDLE, then nominal frame -> err_flags[2]=1, frame stats nominal, frame_cnt=1.
5. Restart: frame_start mid-line 10, then full nominal frame -> err_flags=4'b1000, exactly one frame_done, frame_cnt=1.
6. Reset mid-frame: rst_n=0 during line 20 for 2 cycles -> all outputs 0 immediately; following nominal frame gives frame_cnt=1, err_flags=0.
